// File: rtl/issue_port_arbiter_pkg.sv
// Shared definitions for the issue-port arbiter: port count, functional-unit
// class encodings and default sizing.
package issue_port_arbiter_pkg;

    localparam int NPORT    = 4;
    localparam int NREQ_DEF = 8;
    localparam int OCCW_DEF = 3;

    typedef enum logic [1:0] {
        FU_ALU0   = 2'd0,
        FU_ALU1   = 2'd1,
        FU_MEM    = 2'd2,
        FU_MULDIV = 2'd3
    } fu_class_e;

endpackage

// File: rtl/issue_port_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr_i, wrapping to 0.
// The one-hot grant and any-valid flag are gated by en_i.
module issue_port_arbiter_rr_pick #(
    parameter int NREQ = 8,
    parameter int IDXW = 3
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    logic [NREQ-1:0] gnt_s;
    logic [IDXW-1:0] idx_s;
    logic [IDXW-1:0] cand_s;
    logic            hit_s;
    logic            found_s;

    // Scan candidates in priority order starting at the pointer
    always_comb begin
        gnt_s   = '0;
        idx_s   = '0;
        cand_s  = '0;
        hit_s   = 1'b0;
        found_s = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            cand_s         = IDXW'((int'(ptr_i) + off) % NREQ);
            hit_s          = !found_s && req_i[cand_s];
            gnt_s[cand_s]  = gnt_s[cand_s] | hit_s;
            idx_s          = hit_s ? cand_s : idx_s;
            found_s        = found_s | hit_s;
        end
    end

    assign gnt_o = en_i ? gnt_s : '0;
    assign idx_o = idx_s;
    assign any_o = en_i & found_s;

endmodule

// File: rtl/issue_port_arbiter.sv
// Per-port round-robin issue arbiter with occupancy stalls for multi-cycle units.
// o_grant is same-cycle; o_valid/o_sel are registered one cycle later.
module issue_port_arbiter
    import issue_port_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDXW = $clog2(NREQ),
    parameter int OCCW = OCCW_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREQ-1:0]       i_req,
    input  logic [2*NREQ-1:0]     i_class,
    input  logic [OCCW*NREQ-1:0]  i_occ,
    input  logic                  i_flush,
    input  logic                  i_stall,
    output logic [NREQ-1:0]       o_grant,
    output logic [NPORT-1:0]      o_valid,
    output logic [NPORT*IDXW-1:0] o_sel,
    output logic [NPORT-1:0]      o_busy
);

    logic [NPORT-1:0][NREQ-1:0] elig_s;
    logic [NPORT-1:0][NREQ-1:0] pick_gnt_s;
    logic [NPORT-1:0][IDXW-1:0] pick_idx_s;
    logic [NPORT-1:0]           pick_any_s;
    logic [NPORT-1:0]           pick_en_s;
    logic [NREQ-1:0]            grant_s;

    logic [NPORT-1:0][IDXW-1:0] ptr_q, ptr_d;
    logic [NPORT-1:0][IDXW-1:0] sel_q, sel_d;
    logic [NPORT-1:0][OCCW-1:0] cnt_q, cnt_d;
    logic [NPORT-1:0]           valid_q, valid_d;

    // Eligibility per port and enable gating (reset, flush, stall, unit busy)
    always_comb begin
        elig_s    = '0;
        pick_en_s = '0;
        for (int p = 0; p < NPORT; p++) begin
            for (int n = 0; n < NREQ; n++) begin
                elig_s[p][n] = i_req[n] && (i_class[2*n +: 2] == fu_class_e'(p));
            end
            pick_en_s[p] = i_rst_n && !i_flush && !i_stall && (cnt_q[p] == '0);
        end
    end

    for (genvar gp = 0; gp < NPORT; gp++) begin : g_port
        issue_port_arbiter_rr_pick #(
            .NREQ (NREQ),
            .IDXW (IDXW)
        ) u_pick (
            .req_i (elig_s[gp]),
            .ptr_i (ptr_q[gp]),
            .en_i  (pick_en_s[gp]),
            .gnt_o (pick_gnt_s[gp]),
            .idx_o (pick_idx_s[gp]),
            .any_o (pick_any_s[gp])
        );
    end

    // Merge per-port grants; classes are disjoint so no bit is granted twice
    always_comb begin
        grant_s = '0;
        for (int p = 0; p < NPORT; p++) begin
            grant_s = grant_s | pick_gnt_s[p];
        end
    end

    // Next-state: flush beats stall beats grant; counters drain regardless of stall
    always_comb begin
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        for (int p = 0; p < NPORT; p++) begin
            cnt_d[p] = (cnt_q[p] != '0) ? cnt_q[p] - OCCW'(1) : '0;
            if (i_flush) begin
                valid_d[p] = 1'b0;
                cnt_d[p]   = '0;
            end else if (i_stall) begin
                valid_d[p] = valid_q[p];
            end else if (pick_any_s[p]) begin
                ptr_d[p]   = (pick_idx_s[p] == IDXW'(NREQ - 1)) ? '0 : pick_idx_s[p] + IDXW'(1);
                cnt_d[p]   = i_occ[OCCW*pick_idx_s[p] +: OCCW];
                valid_d[p] = 1'b1;
                sel_d[p]   = pick_idx_s[p];
            end else begin
                valid_d[p] = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Busy flags straight from the occupancy counters
    always_comb begin
        o_busy = '0;
        for (int p = 0; p < NPORT; p++) begin
            o_busy[p] = (cnt_q[p] != '0);
        end
    end

    assign o_grant = grant_s;
    assign o_valid = valid_q;
    assign o_sel   = sel_q;

endmodule

// File: tb/tb_issue_port_arbiter.sv
// Directed bench for issue_port_arbiter: stimulus queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_issue_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        stall;
    logic [7:0]  req;
    logic [15:0] cls;
    logic [23:0] occ;
    logic [7:0]  o_grant;
    logic [3:0]  o_valid;
    logic [11:0] o_sel;
    logic [3:0]  o_busy;

    typedef struct packed {
        logic [7:0]  grant;
        logic [3:0]  valid;
        logic [11:0] sel;
        logic [3:0]  busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    always #5 clk = ~clk;

    issue_port_arbiter dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (req),
        .i_class (cls),
        .i_occ   (occ),
        .i_flush (flush),
        .i_stall (stall),
        .o_grant (o_grant),
        .o_valid (o_valid),
        .o_sel   (o_sel),
        .o_busy  (o_busy)
    );

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, want);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cyc_no++;
            chk("grant", cyc_no, 32'(o_grant), 32'(mon_e.grant));
            chk("valid", cyc_no, 32'(o_valid), 32'(mon_e.valid));
            chk("sel",   cyc_no, 32'(o_sel),   32'(mon_e.sel));
            chk("busy",  cyc_no, 32'(o_busy),  32'(mon_e.busy));
        end
    end

    task automatic cyc(input logic rs, input logic fl, input logic st,
                       input logic [7:0] rq, input logic [15:0] cl, input logic [23:0] oc,
                       input logic [7:0] eg, input logic [3:0] ev,
                       input logic [11:0] es, input logic [3:0] eb);
        exp_t e;
        #1;
        rst_n = rs;
        flush = fl;
        stall = st;
        req   = rq;
        cls   = cl;
        occ   = oc;
        e = {eg, ev, es, eb};
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        req   = 8'hFF;
        cls   = 16'h0000;
        occ   = 24'h000000;
        @(posedge clk);

        // reset held two cycles with all requests up, then first grant is entry 0
        cyc(1'b0, 1'b0, 1'b0, 8'hFF, 16'h0000, 24'h000000, 8'h00, 4'h0, 12'o0000, 4'h0);
        cyc(1'b0, 1'b0, 1'b0, 8'hFF, 16'h0000, 24'h000000, 8'h00, 4'h0, 12'o0000, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 8'hFF, 16'h0000, 24'h000000, 8'h01, 4'h0, 12'o0000, 4'h0);
        // round-robin over entries 0,3,5 on port 0 (pointer now 1)
        cyc(1'b1, 1'b0, 1'b0, 8'h29, 16'h0000, 24'h000000, 8'h08, 4'h1, 12'o0000, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 8'h29, 16'h0000, 24'h000000, 8'h20, 4'h1, 12'o0003, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 8'h29, 16'h0000, 24'h000000, 8'h01, 4'h1, 12'o0005, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 8'h29, 16'h0000, 24'h000000, 8'h08, 4'h1, 12'o0000, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 24'h000000, 8'h00, 4'h1, 12'o0003, 4'h0);
        // four ports granted in parallel
        cyc(1'b1, 1'b0, 1'b0, 8'h0F, 16'h00E4, 24'h000000, 8'h0F, 4'h0, 12'o0003, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'h00E4, 24'h000000, 8'h00, 4'hF, 12'o3210, 4'h0);
        // occupancy: entry 4 occ=3 blocks entry 6 on port 3 for three cycles
        cyc(1'b1, 1'b0, 1'b0, 8'h50, 16'h3300, 24'h003000, 8'h10, 4'h0, 12'o3210, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 8'h40, 16'h3300, 24'h003000, 8'h00, 4'h8, 12'o4210, 4'h8);
        cyc(1'b1, 1'b0, 1'b0, 8'h40, 16'h3300, 24'h003000, 8'h00, 4'h0, 12'o4210, 4'h8);
        cyc(1'b1, 1'b0, 1'b0, 8'h40, 16'h3300, 24'h003000, 8'h00, 4'h0, 12'o4210, 4'h8);
        cyc(1'b1, 1'b0, 1'b0, 8'h40, 16'h3300, 24'h003000, 8'h40, 4'h0, 12'o4210, 4'h0);
        // flush with port 3 busy (cnt=2) and entry 6 pending
        cyc(1'b1, 1'b0, 1'b0, 8'h10, 16'h3300, 24'h002000, 8'h10, 4'h8, 12'o6210, 4'h0);
        cyc(1'b1, 1'b1, 1'b0, 8'h40, 16'h3300, 24'h002000, 8'h00, 4'h8, 12'o4210, 4'h8);
        cyc(1'b1, 1'b0, 1'b0, 8'h40, 16'h3300, 24'h002000, 8'h40, 4'h0, 12'o4210, 4'h0);
        // stall holds valid/sel, then reset lands during the stall
        cyc(1'b1, 1'b0, 1'b0, 8'hA0, 16'h4000, 24'h000000, 8'hA0, 4'h8, 12'o6210, 4'h0);
        cyc(1'b1, 1'b0, 1'b1, 8'hA0, 16'h4000, 24'h000000, 8'h00, 4'h3, 12'o6275, 4'h0);
        cyc(1'b1, 1'b0, 1'b1, 8'hA0, 16'h4000, 24'h000000, 8'h00, 4'h3, 12'o6275, 4'h0);
        cyc(1'b1, 1'b0, 1'b1, 8'hA0, 16'h4000, 24'h000000, 8'h00, 4'h3, 12'o6275, 4'h0);
        cyc(1'b0, 1'b0, 1'b1, 8'hA0, 16'h4000, 24'h000000, 8'h00, 4'h3, 12'o6275, 4'h0);
        // pointer back at 0 picks entry 3 (a stale pointer of 6 would pick 7)
        cyc(1'b1, 1'b0, 1'b0, 8'h88, 16'h0000, 24'h000000, 8'h08, 4'h0, 12'o0000, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 24'h000000, 8'h00, 4'h1, 12'o0003, 4'h0);

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_port_arbiter.md
Name: issue_port_arbiter

Overview:
- Selects, each cycle, at most one ready issue-queue entry per functional-module port (mod0..mod3) and drives the registered slot selects consumed by the operand-bypass stage.
- Per-port round-robin fairness.
- Per-port occupancy counters stall multi-cycle units (mul/div, mem) until they free up.
- Sits between the issue queue (requesters) and the bypass/operand-routing stage.

Parameters:
- NREQ, 8, number of issue-queue entries (requesters).
- IDXW, 3, requester index width, equal to clog2(NREQ).
- OCCW, 3, width of per-request occupancy (extra busy cycles of the target unit).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_req  in  NREQ  entry n ready to issue.
- i_class  in  2*NREQ  entry n target port, bits [2n+1:2n] (ENMOD encoding).
- i_occ  in  OCCW*NREQ  entry n occupancy k; port is unavailable for k cycles after the grant.
- i_flush  in  1  branch mispredict/kill.
- i_stall  in  1  bypass stage cannot accept.
- o_grant  out  NREQ  combinational same-cycle grant vector; at most one bit per port.
- o_valid  out  4  registered: port p has an instruction this cycle.
- o_sel  out  4*IDXW  registered: port p slot index, bits [IDXW*(p+1)-1:IDXW*p].
- o_busy  out  4  port p occupancy counter is non-zero.

Behaviour:
- Reset is synchronous. While i_rst_n=0 at the clock edge:
  - o_valid=0, o_sel=0.
  - All busy counters=0, so o_busy=0.
  - All round-robin pointers=0.
  - o_grant is 0 combinationally while i_rst_n=0.
- Port p eligibility (elig_p): requesters n with i_req[n]=1 and i_class[n]=p.
- Port p may grant when: i_rst_n=1, i_flush=0, i_stall=0, cnt_p==0, and elig_p is non-zero.
- Pick rule: the first eligible index searching upward from ptr_p, wrapping from NREQ-1 to 0. Ties are impossible.
- On a grant of index g at edge t:
  - ptr_p <= (g+1) mod NREQ.
  - cnt_p <= i_occ[g].
  - o_valid[p] <= 1, o_sel_p <= g.
- Ports with no grant, no stall and no flush: o_valid[p] <= 0; o_sel_p holds its value.
- Timing: latency is 1 cycle from o_grant to o_valid/o_sel. A requester must drop i_req on the cycle after it sees its o_grant bit.
- Occupancy:
  - cnt_p decrements by 1 every cycle while non-zero, regardless of stall; saturates at 0.
  - Grant at t with occ=k: the next grant on that port is no earlier than t+k+1.
  - occ=0 allows back-to-back grants.
- Stall (i_stall=1, i_flush=0):
  - o_grant=0.
  - o_valid and o_sel hold.
  - Pointers hold; counters still decrement.
- Flush (i_flush=1) has priority over stall:
  - o_grant=0.
  - Next edge: o_valid=0, all cnt=0.
  - Pointers hold; o_sel holds.
- Simultaneous grant and counter decrement cannot occur, because a grant requires cnt==0.
- All four ports operate independently in one cycle; up to 4 grants per cycle.
- Requester bits for classes with no request are ignored. An i_occ value on a non-granted entry has no effect.

Decomposition:
- Shared package holds:
  - NPORT=4.
  - Class encodings: FU_ALU0=2'd0, FU_ALU1=2'd1, FU_MEM=2'd2, FU_MULDIV=2'd3.
  - Default NREQ/OCCW.
- One sub-module, rr_pick:
  - Inputs: NREQ-bit request vector, IDXW-bit pointer, enable.
  - Outputs: one-hot grant, binary index, any-valid.
  - Instantiated once per port.
- Counters, pointers and output registers live in the top module.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with i_req=8'hFF -> o_grant=0, o_valid=0, o_sel=0, o_busy=0; first post-reset grant on port 0 is index 0.
- Round-robin: entries 0, 3 and 5 set to class 0, occ=0, requests held -> o_grant per cycle 0x01, 0x08, 0x20, 0x01; o_sel[2:0] one cycle later is 0, 3, 5, 0.
- Parallel: entries 0, 1, 2, 3 set to classes 0, 1, 2, 3 -> o_grant=0x0F in one cycle; next cycle o_valid=4'hF, o_sel=12'o3210 (port p index p, IDXW=3).
- Occupancy:
  - Entry 4 class 3 occ=3 granted at t.
  - Entry 6 class 3 requesting from t -> o_busy[3]=1 for t+1..t+3; entry 6 granted at t+4 (o_grant=0x40).
- Flush:
  - Port 3 cnt=2 and entry 6 class 3 pending; assert i_flush for 1 cycle -> o_grant=0.
  - Next cycle o_valid=0, o_busy=0.
  - Entry 6 granted the cycle after i_flush drops.
- Stall and mid-stall reset:
  - i_stall=1 with o_valid=4'h3, o_sel nonzero, requests pending -> o_grant=0; o_valid/o_sel unchanged for 3 cycles.
  - Assert i_rst_n=0 during the stall -> next edge o_valid=0, o_sel=0, pointers 0.
